// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the multicycle multiply/divide unit.
//   state_t      FSM states (IDLE, MULT, DIV, FIX, DONE)
//   OP_MULT/DIV  encodings of the 'op' input
//   ITER, CNT_W  iteration count and counter width
//   booth_acc_t  {A, Q, Q-1} accumulator; A is 33 bits so A +/- M keeps its sign
//   abs32        32-bit magnitude; |0x80000000| wraps to 0x80000000 as unsigned
package mult_div_pkg;
  localparam int ITER  = 32;
  localparam int CNT_W = 6;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  typedef struct packed {
    logic [32:0] a;
    logic [31:0] q;
    logic        qm1;
  } booth_acc_t;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth iteration (combinational).
//   acc      current {A, Q, Q-1}
//   m        multiplicand M
//   add_b    operand B handed to the shared adder (M sign-extended to 33 bits)
//   add_sub  1 = shared adder subtracts (pair 10), 0 = adds
//   sum      result from the shared adder, A +/- M
//   acc_nxt  next {A, Q, Q-1} after the optional add/sub and arithmetic shift
// The adder lives in the parent so MULT and DIV share one 33-bit unit.
module booth_step
  import mult_div_pkg::*;
(
  input  booth_acc_t  acc,
  input  logic [31:0] m,
  input  logic [32:0] sum,
  output logic [32:0] add_b,
  output logic        add_sub,
  output booth_acc_t  acc_nxt
);
  logic [32:0] a_upd;

  always_comb begin
    add_b   = {m[31], m};
    add_sub = acc.q[0] & ~acc.qm1;
    // 00 / 11: no add, just shift
    a_upd   = (acc.q[0] ^ acc.qm1) ? sum : acc.a;
    acc_nxt.a   = {a_upd[32], a_upd[32:1]};
    acc_nxt.q   = {a_upd[0], acc.q[31:1]};
    acc_nxt.qm1 = acc.q[0];
  end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed MULT/DIV sequencer owning HI/LO.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   start, op     one-cycle request (op 0 = MULT, 1 = DIV), sampled in IDLE
//   a_in, b_in    operands, only needed in the accept cycle
//   busy          high from the cycle after accept through the done cycle
//   done          one-cycle completion pulse
//   div_zero      pulses with done when a DIV had a zero divisor
//   hi_out        upper product word / remainder
//   lo_out        lower product word / quotient
// MULT: 32 Booth steps then DONE (latency 33). DIV: 32 restoring steps on
// magnitudes, then FIX applies signs (latency 34).
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  booth_acc_t       acc;      // MULT: {A, Q, Q-1}; DIV: a = R, q = Q
  logic [31:0]      m_reg;    // multiplicand, or divisor magnitude
  logic             dvd_neg, dvs_neg, dz_flag;
  logic [31:0]      hi, lo;

  // shared 33-bit adder/subtractor
  logic [32:0] add_a, add_b, sum;
  logic        add_sub;
  logic [32:0] bs_add_b;
  logic        bs_sub;
  booth_acc_t  bs_nxt;
  logic [32:0] r_sh;

  booth_step u_booth (
    .acc     (acc),
    .m       (m_reg),
    .sum     (sum),
    .add_b   (bs_add_b),
    .add_sub (bs_sub),
    .acc_nxt (bs_nxt)
  );

  // R < divisor <= 2^31, so the shifted R fits in 32 bits and bit 32 of
  // R - |divisor| is a valid sign.
  assign r_sh = {acc.a[31:0], acc.q[31]};

  always_comb begin
    add_a   = acc.a;
    add_b   = bs_add_b;
    add_sub = bs_sub;
    if (state == DIV) begin
      add_a   = r_sh;
      add_b   = {1'b0, m_reg};
      add_sub = 1'b1;
    end
    sum = add_a + (add_b ^ {33{add_sub}}) + {32'd0, add_sub};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (start) begin
          if (op == OP_MULT)     state_nxt = MULT;
          else if (b_in == '0)   state_nxt = DONE;
          else                   state_nxt = DIV;
        end
      MULT:    if (cnt == LAST) state_nxt = DONE;
      DIV:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      m_reg   <= '0;
      dvd_neg <= 1'b0;
      dvs_neg <= 1'b0;
      dz_flag <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE:
          if (start) begin
            cnt     <= '0;
            dz_flag <= 1'b0;
            if (op == OP_MULT) begin
              m_reg   <= a_in;
              acc.a   <= '0;
              acc.q   <= b_in;
              acc.qm1 <= 1'b0;
            end else if (b_in == '0) begin
              dz_flag <= 1'b1;
            end else begin
              dvd_neg <= a_in[31];
              dvs_neg <= b_in[31];
              m_reg   <= abs32(b_in);
              acc.a   <= '0;
              acc.q   <= abs32(a_in);
              acc.qm1 <= 1'b0;
            end
          end
        MULT: begin
          acc <= bs_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi <= bs_nxt.a[31:0];
            lo <= bs_nxt.q;
          end
        end
        DIV: begin
          acc.a <= sum[32] ? r_sh : sum;
          acc.q <= {acc.q[30:0], ~sum[32]};
          cnt   <= cnt + 1'b1;
        end
        FIX: begin
          lo <= (dvd_neg ^ dvs_neg) ? -acc.q : acc.q;
          hi <= dvd_neg ? -acc.a[31:0] : acc.a[31:0];
        end
        DONE:    dz_flag <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign div_zero = (state == DONE) & dz_flag;
  assign hi_out   = hi;
  assign lo_out   = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  logic        clock, reset, start, op;
  logic [31:0] a_in, b_in;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int n_chk = 0;
  int n_err = 0;

  mult_div_unit #(.ITER(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // sample point: 1 time unit after the rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one request and wait for done; returns the done cycle (0 on timeout).
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    int busy_bad;
    busy_bad = 0;
    lat      = 0;
    start = 1'b1; op = o; a_in = a; b_in = b;
    tick();
    // operands are free to change after the accept edge
    start = 1'b0; a_in = 32'hDEAD_BEEF; b_in = 32'h0;
    for (int c = 1; c <= 60; c++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        lat = c;
        break;
      end
      tick();
    end
    chk("busy_high", busy_bad, 0);
  endtask

  // Check results in the done cycle, then step into the following idle cycle.
  task automatic check_op(input string tag, input int lat, input int lat_e,
                          input logic [31:0] hi_e, input logic [31:0] lo_e,
                          input logic dz_e);
    chk({tag, "_lat"}, lat, lat_e);
    chk({tag, "_hi"}, hi_out, hi_e);
    chk({tag, "_lo"}, lo_out, lo_e);
    chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, dz_e});
    tick();
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int lat, ndone, done_cyc;
    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);

    do_op(1'b0, 32'h0000_0007, 32'hFFFF_FFFD, lat);
    check_op("mul_7xm3", lat, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    // next requests start in the cycle right after done (back-to-back)
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, lat);
    check_op("mul_min2", lat, 33, 32'h4000_0000, 32'h0000_0000, 1'b0);
    do_op(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, lat);
    check_op("mul_max2", lat, 33, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    check_op("mul_m1m1", lat, 33, 32'h0000_0000, 32'h0000_0001, 1'b0);

    do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, lat);
    check_op("div_m7_2", lat, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, lat);
    check_op("div_7_m2", lat, 34, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat);
    check_op("div_m100_m7", lat, 34, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check_op("div_ovf", lat, 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
    // divide by zero keeps HI/LO from the overflow case
    do_op(1'b1, 32'h0000_0005, 32'h0000_0000, lat);
    check_op("div_zero", lat, 1, 32'h0000_0000, 32'h8000_0000, 1'b1);

    // stray starts (as DIV requests) in cycles 5 and 33 of a MULT 6 x 7
    ndone = 0; done_cyc = 0;
    start = 1'b1; op = 1'b0; a_in = 32'd6; b_in = 32'd7;
    tick();
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 33);
      op = 1'b1; a_in = 32'd100; b_in = 32'd3;
      if (done === 1'b1) begin
        ndone++;
        done_cyc = c;
      end
      tick();
    end
    start = 1'b0;
    chk("poke_ndone", ndone, 1);
    chk("poke_cyc", done_cyc, 33);
    chk("poke_lo", lo_out, 32'd42);
    chk("poke_hi", hi_out, 32'd0);
    chk("poke_idle", {31'd0, busy}, 32'd0);

    // reset in cycle 10 of a DIV
    start = 1'b1; op = 1'b1; a_in = 32'd100; b_in = 32'd7;
    tick();
    start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_div_busy", {31'd0, busy}, 32'd0);
    chk("rst_div_hi", hi_out, 32'd0);
    chk("rst_div_lo", lo_out, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("rst_div_nodone", ndone, 0);

    do_op(1'b0, 32'd3, 32'd4, lat);
    check_op("mul_3x4", lat, 33, 32'd0, 32'd12, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
